// File: rtl/sram_array_ctrl.sv
// Request sequencer for a ROWS x COLS SRAM bitcell array: wordline/bitline/row-select timing and read capture.
// Define SRAM_CTRL_VERIFY_EN to add a read-back compare after every write (result on err).
module sram_array_ctrl #(
  parameter int AW        = 3,
  parameter int COLS      = 8,
  parameter int WL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [COLS-1:0]     wdata,
  output logic                busy,
  output logic                ack,
  output logic [COLS-1:0]     rdata,
  output logic                err,
  output logic [(1<<AW)-1:0]  wl,
  output logic [COLS-1:0]     bl,
  output logic [(1<<AW)-1:0]  rsel,
  input  logic [COLS-1:0]     q_in
);
  localparam int ROWS = 1 << AW;

  if (WL_CYCLES < 1 || WL_CYCLES > 15) begin : g_bad_wl_cycles
    $error("sram_array_ctrl: WL_CYCLES must be in 1..15");
  end

  localparam logic [3:0] WL_LAST = 4'(WL_CYCLES - 1);
  localparam logic [3:0] SENSE_LAST = 4'd1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACT, S_HOLD, S_SENSE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [COLS-1:0]   wdata_q, wdata_d;
  logic [COLS-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic [ROWS-1:0]   wl_q, wl_d;
  logic [COLS-1:0]   bl_q, bl_d;
  logic [ROWS-1:0]   rsel_q, rsel_d;
  logic [ROWS-1:0]   row_oh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req) begin
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        state_d = we ? S_SETUP : S_SENSE;
        cnt_d   = SENSE_LAST;
      end
      S_SETUP: begin
        state_d = S_ACT;
        cnt_d   = WL_LAST;
      end
      S_ACT: begin
        if (cnt_q == 4'd0) state_d = S_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_HOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
        state_d = S_SENSE;
        cnt_d   = SENSE_LAST;
`else
        state_d = S_DONE;
`endif
      end
      S_SENSE: begin
        if (cnt_q == 4'd0) begin
          // q_in has settled through the row mux for two cycles; capture it on entry to DONE
          state_d = S_DONE;
          if (!we_q) rdata_d = q_in;
`ifdef SRAM_CTRL_VERIFY_EN
          if (we_q) err_d = (q_in != wdata_q);
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifndef SRAM_CTRL_VERIFY_EN
    err_d = 1'b0;
`endif
  end

  // Outputs are registered copies of the decode of the next state, so they line up with state_q.
  always_comb begin
    row_oh = {{(ROWS-1){1'b0}}, 1'b1} << addr_d;
    busy_d = (state_d != S_IDLE);
    ack_d  = (state_d == S_DONE);
    wl_d   = (state_d == S_ACT) ? row_oh : '0;
    rsel_d = (state_d == S_SENSE) ? row_oh : '0;
    bl_d   = (state_d == S_SETUP || state_d == S_ACT || state_d == S_HOLD) ? wdata_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      wl_q    <= '0;
      bl_q    <= '0;
      rsel_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      wl_q    <= wl_d;
      bl_q    <= bl_d;
      rsel_q  <= rsel_d;
    end
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign wl    = wl_q;
  assign bl    = bl_q;
  assign rsel  = rsel_q;

endmodule

// File: doc/sram_array_ctrl.md
# sram_array_ctrl

Sequencer for a ROWS×COLS array of SRAM bitcells. Each cell is written whenever its wordline is high, taking the value on its bitline; otherwise it holds its value and continuously drives Q. Because of that, this block guarantees that a wordline is never high during a read and never high while the bitlines change. It accepts single read/write requests from a host, generates the wordline, bitline and row-select timing, and captures read data from the array's Q outputs.

## Interface
Parameters:
- AW, 3, address width; ROWS = 2**AW
- COLS, 8, word width (bitcells per row)
- WL_CYCLES, 2, wordline pulse width in cycles; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  AW  row address; latched with req
- wdata  in  COLS  write data; latched with req
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse (DONE state)
- rdata  out  COLS  read data; valid with ack of a read, held until the next read completes
- err  out  1  verify result; updated at ack, held until the next ack
- wl  out  ROWS  one-hot wordlines to the array
- bl  out  COLS  bitline drive to the array
- rsel  out  ROWS  one-hot row select for the array's Q read mux
- q_in  in  COLS  Q outputs of the selected row

## Operation
- Single clock, asynchronous active-low reset.
- All outputs are registered; nothing combinational runs from an input to an output.
- States:
  - IDLE: req=1 latches we/addr/wdata and goes to SETUP (write) or SENSE (read). No request queue.
  - SETUP (write, 1 cycle): bl = wdata_latched, wl = 0.
  - ACT (WL_CYCLES cycles): wl = one-hot(addr); bl held. A 4-bit down-counter sets the duration.
  - HOLD (1 cycle): wl = 0, bl still held. Next state is DONE, or SENSE when verify is compiled in.
  - SENSE (2 cycles): rsel = one-hot(addr), wl = 0. q_in is captured at the end of the second cycle.
  - DONE (1 cycle): ack = 1. Next state is IDLE.
- bl = 0 and rsel = 0 outside the states listed above.
- wl is high only in ACT.
- A read updates rdata with the captured q_in on entry to DONE. A write leaves rdata unchanged.
- req while busy is ignored; it is not stored and produces no ack. The host must re-issue it after busy falls.
- The minimum spacing between ops is one IDLE cycle.
- Reset values: state IDLE; wl, bl, rsel, rdata all zero; ack = 0, busy = 0, err = 0.
- Reset mid-operation: all outputs drop to their reset values immediately (asynchronously) and the aborted op never acks. A write aborted in ACT may leave the target row partially written. That is acceptable and the host is responsible for it.
- WL_CYCLES outside 1..15 is illegal. The implementation must halt simulation with $error at elaboration.

## Timing
Cycle n is the cycle after the clock edge at which req is accepted.
- Write: SETUP at cycle 1; ACT at cycles 2..1+WL_CYCLES; HOLD at 2+WL_CYCLES; ack at 3+WL_CYCLES. With the defaults, ack is at cycle 5.
- Read: SENSE at cycles 1–2; ack and rdata valid at cycle 3.
- Write with verify: after HOLD, SENSE for 2 cycles, then ack at 5+WL_CYCLES.
- busy is high from cycle 1 through the ack cycle inclusive.
- bl is stable for one cycle on each side of the wl pulse.

## Configuration
- SRAM_CTRL_VERIFY_EN defined:
  - Each write performs a read-back: HOLD → SENSE → DONE.
  - The captured q_in is compared against wdata_latched.
  - err = 1 on mismatch, 0 on match, updated on entry to DONE.
  - Reads leave err unchanged.
- Undefined: no read-back; HOLD → DONE; err is constant 0.

## Test plan
Defaults: AW=3, COLS=8, WL_CYCLES=2.
- **Reset:** assert rst_n=0 mid-clock → wl, bl, rsel, rdata = 0 and ack, busy, err = 0 immediately, with no clock edge required.
- **Write:** write addr=5, wdata=0xA5 → wl=0x20 in cycles 2–3 only; bl=0xA5 in cycles 1–4; ack in cycle 5 only; busy high in cycles 1–5; wl=0 in every other cycle.
- **Read:** read addr=5 with the array model holding 0xA5 → rsel=0x20 in cycles 1–2; wl=0 throughout; rdata=0xA5 with ack in cycle 3; rdata still 0xA5 after a subsequent write.
- **Req while busy:** req=1 in cycles 2–4 of a write → exactly one ack; the op with the next req accepted in IDLE completes normally.
- **Reset mid-ACT:** rst_n low during cycle 2 of a write, then released → wl drops to 0 at once; no ack follows; the next read request is accepted normally.
- **Verify (macro on):** write 0xA5 with q_in forced to 0xA4 → err=1 with ack in cycle 7. A repeat with the correct q_in → err=0. With the macro off, the same write acks in cycle 5 with err=0.
